// File: rtl/calc_pkg.sv
// Shared key codes, operator encoding and entry-state enum for the calculator datapath.
package calc_pkg;

  localparam int unsigned KEY_W   = 5;
  localparam int unsigned BCD_W   = 4;

  localparam logic [KEY_W-1:0] KEY_ADD  = 5'd10;
  localparam logic [KEY_W-1:0] KEY_SUB  = 5'd11;
  localparam logic [KEY_W-1:0] KEY_MUL  = 5'd12;
  localparam logic [KEY_W-1:0] KEY_DIV  = 5'd13;
  localparam logic [KEY_W-1:0] KEY_EQ   = 5'd14;
  localparam logic [KEY_W-1:0] KEY_CLR  = 5'd15;
  localparam logic [KEY_W-1:0] KEY_NONE = 5'd17;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_REQ  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Operator keys 10..13 map directly onto the op encoding.
  function automatic op_e key_to_op(input logic [KEY_W-1:0] k);
    return op_e'(2'(k - KEY_ADD));
  endfunction

endpackage

// File: rtl/calc_bcd_shift.sv
// BCD digit-insert register with digit count, leading-zero suppression, clear and parallel load.
module calc_bcd_shift
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic [BCD_W*DIGITS-1:0] load_val_i,
  input  logic                    dig_vld_i,
  input  logic [BCD_W-1:0]        dig_i,
  output logic [BCD_W*DIGITS-1:0] val_o,
  output logic [BCD_W*DIGITS-1:0] val_d_c
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  logic [W-1:0]     val_q, val_d, base_val;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;

  // Clear acts first so a clear and a digit in the same cycle start a fresh operand.
  always_comb begin
    base_val = clr_i ? '0 : val_q;
    base_cnt = clr_i ? '0 : cnt_q;
    val_d    = base_val;
    cnt_d    = base_cnt;
    if (load_i) begin
      val_d = load_val_i;
      cnt_d = CNT_W'(DIGITS);
    end else if (dig_vld_i && (base_cnt < CNT_W'(DIGITS)) &&
                 !((base_cnt == '0) && (dig_i == '0))) begin
      val_d = W'({base_val, dig_i});
      cnt_d = base_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign val_o   = val_q;
  assign val_d_c = val_d;

endmodule

// File: rtl/calc_entry.sv
// Keypad entry stage: key-event detect, operand/operator assembly and req/ack hand-off to the ALU.
module calc_entry
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [KEY_W-1:0]        key_code_i,
  input  logic                    ack_i,
  input  logic [BCD_W*DIGITS-1:0] result_bcd_i,
  input  logic                    result_err_i,
  output logic [BCD_W*DIGITS-1:0] operand_a_o,
  output logic [BCD_W*DIGITS-1:0] operand_b_o,
  output logic [1:0]              op_o,
  output logic                    req_o,
  output logic [BCD_W*DIGITS-1:0] disp_bcd_o,
  output logic                    disp_err_o
);

  localparam int unsigned W = BCD_W * DIGITS;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [KEY_W-1:0] prev_q, key_n;
  logic [W-1:0]     res_q, res_d, disp_q, disp_d;
  logic             err_q, err_d, req_q, req_d;
  logic             ev, is_dig, is_op, is_eq, is_clr;
  logic             a_clr, a_load, a_dig, b_clr, b_dig;
  logic [W-1:0]     a_d, b_d;

  // Out-of-range codes behave as "no key".
  assign key_n  = (key_code_i <= KEY_CLR) ? key_code_i : KEY_NONE;
  assign ev     = (key_n != KEY_NONE) && (key_n != prev_q);
  assign is_dig = ev && (key_n < KEY_ADD);
  assign is_op  = ev && (key_n >= KEY_ADD) && (key_n <= KEY_DIV);
  assign is_eq  = ev && (key_n == KEY_EQ);
  assign is_clr = ev && (key_n == KEY_CLR);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    a_clr   = 1'b0;
    a_load  = 1'b0;
    a_dig   = 1'b0;
    b_clr   = 1'b0;
    b_dig   = 1'b0;
    if (is_clr) begin
      a_clr   = 1'b1;
      b_clr   = 1'b1;
      res_d   = '0;
      err_d   = 1'b0;
      op_d    = OP_ADD;
      state_d = S_A;
    end else begin
      case (state_q)
        S_A: begin
          if (is_dig) a_dig = 1'b1;
          else if (is_op) begin
            op_d    = key_to_op(key_n);
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (is_op) op_d = key_to_op(key_n);
          else if (is_dig) begin
            b_clr   = 1'b1;
            b_dig   = 1'b1;
            state_d = S_B;
          end
        end
        S_B: begin
          if (is_dig) b_dig = 1'b1;
          else if (is_eq) state_d = S_REQ;
        end
        S_REQ: begin
          if (ack_i) begin
            res_d   = result_bcd_i;
            err_d   = result_err_i;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (is_dig) begin
            a_clr   = 1'b1;
            a_dig   = 1'b1;
            err_d   = 1'b0;
            state_d = S_A;
          end else if (is_op && !err_q) begin
            a_load  = 1'b1;
            op_d    = key_to_op(key_n);
            state_d = S_OP;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  // Registered outputs are derived from next-state values so they move on the same edge.
  always_comb begin
    req_d = (state_d == S_REQ);
    case (state_d)
      S_B, S_REQ: disp_d = b_d;
      S_DONE:     disp_d = res_d;
      default:    disp_d = a_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_A;
      prev_q  <= KEY_NONE;
      op_q    <= OP_ADD;
      res_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= key_n;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      req_q   <= req_d;
      disp_q  <= disp_d;
    end
  end

  calc_bcd_shift #(.DIGITS(DIGITS)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (a_clr),
    .load_i     (a_load),
    .load_val_i (res_q),
    .dig_vld_i  (a_dig),
    .dig_i      (key_n[BCD_W-1:0]),
    .val_o      (operand_a_o),
    .val_d_c    (a_d)
  );

  calc_bcd_shift #(.DIGITS(DIGITS)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (b_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .dig_vld_i  (b_dig),
    .dig_i      (key_n[BCD_W-1:0]),
    .val_o      (operand_b_o),
    .val_d_c    (b_d)
  );

  assign op_o       = op_q;
  assign req_o      = req_q;
  assign disp_bcd_o = disp_q;
  assign disp_err_o = err_q;

endmodule

// File: tb/tb_calc_entry.sv
// Directed bench for calc_entry: key sequences with hand-computed operand/op/req/display values.
module tb_calc_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  key_code;
  logic        ack;
  logic [15:0] result_bcd;
  logic        result_err;
  logic [15:0] operand_a, operand_b, disp_bcd;
  logic [1:0]  op;
  logic        req, disp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_entry #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code_i   (key_code),
    .ack_i        (ack),
    .result_bcd_i (result_bcd),
    .result_err_i (result_err),
    .operand_a_o  (operand_a),
    .operand_b_o  (operand_b),
    .op_o         (op),
    .req_o        (req),
    .disp_bcd_o   (disp_bcd),
    .disp_err_o   (disp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a key code for exactly one active edge, then sample 1ns later.
  task automatic key_edge(input logic [4:0] k);
    key_code = k;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] k);
    key_edge(k);
    key_edge(5'd17);
  endtask

  initial begin
    rst_n      = 1'b0;
    key_code   = 5'd17;
    ack        = 1'b0;
    result_bcd = '0;
    result_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_operand_a", operand_a, 0);
    chk("rst_operand_b", operand_b, 0);
    chk("rst_op", op, 0);
    chk("rst_req", req, 0);
    chk("rst_disp_bcd", disp_bcd, 0);
    chk("rst_disp_err", disp_err, 0);
    rst_n = 1'b1;
    key_edge(5'd17);

    // 12 + 3 =
    press(5'd1);
    chk("a_after_1", operand_a, 16'h0001);
    press(5'd2);
    chk("a_after_12", operand_a, 16'h0012);
    press(5'd10);
    press(5'd3);
    chk("disp_b_3", disp_bcd, 16'h0003);
    key_edge(5'd14);
    chk("req_rise", req, 1);
    chk("eq_operand_a", operand_a, 16'h0012);
    chk("eq_operand_b", operand_b, 16'h0003);
    chk("eq_op", op, 0);
    key_edge(5'd17);
    chk("req_held", req, 1);
    ack = 1'b1; result_bcd = 16'h0015;
    key_edge(5'd17);
    ack = 1'b0;
    chk("ack_req_low", req, 0);
    chk("ack_disp", disp_bcd, 16'h0015);
    chk("ack_err", disp_err, 0);

    // chain: - 5 =
    press(5'd11);
    chk("chain_a", operand_a, 16'h0015);
    chk("chain_op", op, 1);
    press(5'd5);
    key_edge(5'd14);
    chk("chain_req", req, 1);
    chk("chain_b", operand_b, 16'h0005);
    ack = 1'b1; result_bcd = 16'h0010; result_err = 1'b1;
    key_edge(5'd17);
    ack = 1'b0; result_err = 1'b0;
    chk("err_disp_err", disp_err, 1);
    press(5'd12);
    chk("err_op_ignored", op, 1);
    chk("err_disp_kept", disp_bcd, 16'h0010);
    press(5'd15);
    chk("clr_a", operand_a, 0);
    chk("clr_op", op, 0);
    chk("clr_err", disp_err, 0);

    // leading zeros and digit overflow
    press(5'd0); press(5'd0); press(5'd7);
    chk("lead_zero_a", operand_a, 16'h0007);
    press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
    chk("full_a", operand_a, 16'h7123);
    chk("full_disp", disp_bcd, 16'h7123);

    // operator replacement with empty A
    press(5'd15);
    press(5'd10); press(5'd11); press(5'd12);
    chk("op_replace", op, 2);
    chk("op_empty_a", operand_a, 0);
    press(5'd9);
    key_edge(5'd14);
    chk("mul_req", req, 1);
    chk("mul_b", operand_b, 16'h0009);

    // C with same-cycle ack: C wins
    ack = 1'b1; result_bcd = 16'h0099;
    key_edge(5'd15);
    ack = 1'b0;
    chk("cack_req", req, 0);
    chk("cack_a", operand_a, 0);
    chk("cack_b", operand_b, 0);
    chk("cack_disp", disp_bcd, 0);
    key_edge(5'd17);
    press(5'd3);
    chk("cack_state_a", operand_a, 16'h0003);

    // held key produces one event; 4,17,4 gives two more
    press(5'd15);
    key_code = 5'd4;
    repeat (100) @(posedge clk);
    #1;
    key_edge(5'd17);
    chk("hold_one", operand_a, 16'h0004);
    press(5'd4); press(5'd4);
    chk("retrigger", operand_a, 16'h0444);
    press(5'd16); press(5'd31);
    chk("bad_codes_ignored", operand_a, 16'h0444);

    // reset mid-request
    press(5'd10); press(5'd1);
    key_edge(5'd14);
    chk("pre_rst_req", req, 1);
    rst_n = 1'b0;
    key_edge(5'd17);
    chk("rst_mid_req", req, 0);
    chk("rst_mid_a", operand_a, 0);
    rst_n = 1'b1;
    key_edge(5'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
